// File: rtl/pc_next_if.sv
// PC-stage control/status bundle between instruction decode and the program-counter unit.
// Optional branch statistics outputs appear only when BRANCH_STATS_EN is defined.
interface pc_next_if;
    logic        stall;
    logic        branch;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] bad_addr;
    logic        halted;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;
`endif

    modport master (
        output stall, branch, branch_taken, jal, jalr, imm, rs1,
`ifdef BRANCH_STATS_EN
        input  branch_cnt, taken_cnt,
`endif
        input  pc, pc_plus4, trap, bad_addr, halted
    );

    modport slave (
        input  stall, branch, branch_taken, jal, jalr, imm, rs1,
`ifdef BRANCH_STATS_EN
        output branch_cnt, taken_cnt,
`endif
        output pc, pc_plus4, trap, bad_addr, halted
    );
endinterface

// File: rtl/pc_next_unit.sv
// RV32I program-counter stage: next-PC select, misaligned-target trap and double-fault halt.
// Define BRANCH_STATS_EN to add the retired/taken conditional-branch counters.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input logic       clk,
    input logic       rst,
    pc_next_if.slave  bus
);

    typedef enum logic [1:0] {StRun, StTrap, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        trap_q, trap_d;
    logic        halted_q, halted_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;
    logic        misalign;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        redirect = bus.jalr | bus.jal | (bus.branch & bus.branch_taken);
        target   = bus.jalr ? ((bus.rs1 + bus.imm) & ~32'h1) : (pc_q + bus.imm);
        misalign = redirect && (target[1:0] != 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bad_addr_d = bad_addr_q;
        if (!bus.stall) begin
            unique case (state_q)
                StRun: begin
                    if (misalign) begin
                        pc_d       = TRAP_VEC;
                        bad_addr_d = target;
                        state_d    = StTrap;
                    end else begin
                        pc_d = redirect ? target : pc_plus4;
                    end
                end
                StTrap: begin
                    // Second fault while the handler's first instruction runs: give up.
                    if (misalign) begin
                        bad_addr_d = target;
                        state_d    = StHalt;
                    end else begin
                        pc_d    = redirect ? target : pc_plus4;
                        state_d = StRun;
                    end
                end
                default: ;
            endcase
        end
        trap_d   = (state_d == StTrap);
        halted_d = (state_d == StHalt);
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (!bus.stall && state_q != StHalt && bus.branch) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (bus.branch_taken) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign bus.branch_cnt = branch_cnt_q;
    assign bus.taken_cnt  = taken_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            bad_addr_q <= 32'd0;
            trap_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bad_addr_q <= bad_addr_d;
            trap_q     <= trap_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.trap     = trap_q;
    assign bus.bad_addr = bad_addr_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed plus random bench for pc_next_unit, checked against an architectural PC model.
module tb_pc_next_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0100;
    localparam int MODE_RUN  = 0;
    localparam int MODE_TRAP = 1;
    localparam int MODE_HALT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_next_if bus ();

    pc_next_unit #(
        .RESET_PC (RST_PC),
        .TRAP_VEC (TVEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Architectural model state
    logic [31:0] m_pc, m_bad, m_bcnt, m_tcnt;
    int          m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("pc", bus.pc, m_pc);
        chk("trap", {31'd0, bus.trap}, {31'd0, m_mode == MODE_TRAP});
        chk("halted", {31'd0, bus.halted}, {31'd0, m_mode == MODE_HALT});
        chk("bad_addr", bus.bad_addr, m_bad);
`ifdef BRANCH_STATS_EN
        chk("branch_cnt", bus.branch_cnt, m_bcnt);
        chk("taken_cnt", bus.taken_cnt, m_tcnt);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.stall = 1'b0; bus.branch = 1'b0; bus.branch_taken = 1'b0;
        bus.jal = 1'b0; bus.jalr = 1'b0; bus.imm = 32'd0; bus.rs1 = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RST_PC; m_bad = 32'd0; m_bcnt = 32'd0; m_tcnt = 32'd0; m_mode = MODE_RUN;
        check_state();
    endtask

    // One instruction: drive, check link value, advance model and DUT, compare.
    task automatic step(input logic st, input logic br, input logic tk, input logic j,
                        input logic jr, input logic [31:0] im, input logic [31:0] r1);
        logic [31:0] tgt;
        logic        taken;
        bus.stall = st; bus.branch = br; bus.branch_taken = tk;
        bus.jal = j; bus.jalr = jr; bus.imm = im; bus.rs1 = r1;
        #1;
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        if (!st && m_mode != MODE_HALT) begin
            if (br) begin
                m_bcnt++;
                if (tk) m_tcnt++;
            end
            taken = jr || j || (br && tk);
            if (jr) tgt = (r1 + im) & 32'hFFFF_FFFE;
            else    tgt = m_pc + im;
            if (taken && (tgt % 4 != 0)) begin
                m_bad = tgt;
                if (m_mode == MODE_RUN) begin
                    m_pc   = TVEC;
                    m_mode = MODE_TRAP;
                end else begin
                    m_mode = MODE_HALT;
                end
            end else begin
                m_pc   = taken ? tgt : m_pc + 32'd4;
                m_mode = MODE_RUN;
            end
        end
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic jump_to(input logic [31:0] dest);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dest - m_pc, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_pc", bus.pc, 32'h0);
        idle(); idle(); idle();
        chk("idle_pc", bus.pc, 32'hC);

        jump_to(32'h40);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        chk("br_taken", bus.pc, 32'h38);
        jump_to(32'h40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        chk("br_not_taken", bus.pc, 32'h44);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
        chk("taken_ignored", bus.pc, 32'h48);

        jump_to(32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h203);
        chk("jalr_trap_pc", bus.pc, 32'h100);
        chk("jalr_bad", bus.bad_addr, 32'h202);
        chk("jalr_trap", {31'd0, bus.trap}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 32'd0);
        chk("trap_held_stall", {31'd0, bus.trap}, 32'd1);
        idle();
        chk("trap_cleared", {31'd0, bus.trap}, 32'd0);

        jump_to(32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h203);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 32'd0);
        chk("halt", {31'd0, bus.halted}, 32'd1);
        chk("halt_pc", bus.pc, 32'h100);
        chk("halt_bad", bus.bad_addr, 32'h106);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3, 32'd0);
        chk("halt_frozen", bus.pc, 32'h100);
        do_reset();
        chk("halt_reset_pc", bus.pc, 32'h0);

        // Stall with a taken branch presented, then release
        jump_to(32'h200);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
        chk("stall_pc", bus.pc, 32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
        chk("stall_release", bus.pc, 32'h220);

        // Sequential wrap without fault
        jump_to(32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_no_trap", {31'd0, bus.trap}, 32'd0);

`ifdef BRANCH_STATS_EN
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'd0);
        chk("branch_cnt5", bus.branch_cnt, 32'd5);
        chk("taken_cnt2", bus.taken_cnt, 32'd2);
`endif

        // Random instruction stream
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, im, r1;
            int          kind;
            r  = $urandom;
            im = {{22{r[9]}}, r[9:2], 2'b00};
            if (r[12:10] == 3'd0) im[1] = 1'b1;
            if (r[15:13] == 3'd1) im[0] = 1'b1;
            r1 = $urandom & 32'h0000_0FFC;
            if (r[18:16] == 3'd0) r1[1:0] = r[20:19];
            kind = int'(r[23:21]);
            if (m_mode == MODE_HALT && r[24]) begin
                do_reset();
            end else begin
                step(r[27:25] == 3'd0, kind inside {[0:2]}, r[28], kind == 3, kind == 4, im, r1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
